lc3b_mem_arbiter: RTL and testbench

- Shares one physical memory port between the LC-3b instruction-fetch side (read-only) and the data side (read/write, byte-masked).
- Sits between the CPU datapath/control and the memory model.
- Serves one transaction at a time, with registered memory-side outputs.
- Has a response watchdog that aborts hung transactions and flags a sticky error.

---
 rtl/lc3b_mem_arbiter_pkg.sv | 23 ++
 rtl/lc3b_arb_watchdog.sv | 56 +++++
 rtl/lc3b_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_lc3b_mem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter: data word, byte mask, FSM state and port ids.
package lc3b_mem_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        arb_idle,
        arb_busy_i,
        arb_busy_d
    } lc3b_arb_state;

    typedef enum bit {
        arb_port_i,
        arb_port_d
    } lc3b_arb_port;

    // Instruction fetches are always word aligned on the memory side.
    function automatic lc3b_word fetch_align(input lc3b_word addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/lc3b_arb_watchdog.sv
// Response watchdog: counts busy cycles without mem_resp, signals expiry and holds a sticky error.
module lc3b_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy_entry,
    input  logic busy,
    input  logic mem_resp,
    input  logic clr,
    output logic expire,
    output logic err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // cnt_q holds the number of finished busy cycles, so the current cycle is number cnt_q+1.
    generate
        if (TIMEOUT > 0) begin : g_wd
            assign expire = busy && (cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_wd
            assign expire = 1'b0;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (busy_entry) begin
            cnt_d = '0;
        end else if (busy && !mem_resp) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q;
        if (expire && !mem_resp) begin
            err_d = 1'b1;
        end else if (clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Fetch/data memory arbiter with registered memory strobes and a response watchdog.
// Optional round-robin grant on collisions: define LC3B_ARB_RR_EN (default is D-over-I priority).
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_read,
    input  lc3b_word      i_addr,
    output logic          i_resp,
    output lc3b_word      i_rdata,
    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_word      d_addr,
    input  lc3b_word      d_wdata,
    input  lc3b_mem_wmask d_wmask,
    output logic          d_resp,
    output lc3b_word      d_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output lc3b_word      mem_addr,
    output lc3b_word      mem_wdata,
    output lc3b_mem_wmask mem_wmask,
    input  logic          mem_resp,
    input  lc3b_word      mem_rdata,
    input  logic          timeout_clr,
    output logic          timeout_err
);

    lc3b_arb_state state_q, state_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    lc3b_word      mem_addr_q, mem_addr_d;
    lc3b_word      mem_wdata_q, mem_wdata_d;
    lc3b_mem_wmask mem_wmask_q, mem_wmask_d;

    logic d_req, grant_d, busy, busy_entry, expire, done;

    assign d_req = d_read || d_write;
    assign busy  = (state_q != arb_idle);
    assign done  = mem_resp || expire;

`ifdef LC3B_ARB_RR_EN
    lc3b_arb_port last_grant_q, last_grant_d;

    assign grant_d = d_req && (!i_read || (last_grant_q == arb_port_i));

    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == arb_idle) && (d_req || i_read)) begin
            last_grant_d = grant_d ? arb_port_d : arb_port_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= arb_port_i;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        busy_entry  = 1'b0;
        case (state_q)
            arb_idle: begin
                if (d_req || i_read) begin
                    busy_entry = 1'b1;
                    if (grant_d) begin
                        state_d     = arb_busy_d;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        // A simultaneous read and write request is served as a write.
                        mem_write_d = d_write;
                        mem_read_d  = !d_write;
                        mem_wmask_d = d_write ? d_wmask : 2'b00;
                    end else begin
                        state_d     = arb_busy_i;
                        mem_addr_d  = fetch_align(i_addr);
                        mem_wdata_d = '0;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                        mem_wmask_d = 2'b00;
                    end
                end
            end
            arb_busy_i, arb_busy_d: begin
                if (done) begin
                    state_d     = arb_idle;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d     = arb_idle;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= arb_idle;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
        end
    end

    lc3b_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy_entry (busy_entry),
        .busy       (busy),
        .mem_resp   (mem_resp),
        .clr        (timeout_clr),
        .expire     (expire),
        .err        (timeout_err)
    );

    assign i_resp    = (state_q == arb_busy_i) && done;
    assign d_resp    = (state_q == arb_busy_d) && done;
    assign i_rdata   = ((state_q == arb_busy_i) && mem_resp) ? mem_rdata : '0;
    assign d_rdata   = ((state_q == arb_busy_d) && mem_resp) ? mem_rdata : '0;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: the bench plays CPU and memory and predicts every cycle.
module tb_lc3b_mem_arbiter;

    localparam int TO = 4;
`ifdef LC3B_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        i_read, i_resp;
    logic [15:0] i_addr, i_rdata;
    logic        d_read, d_write, d_resp;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_wmask;
    logic        mem_read, mem_write, mem_resp;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_wmask;
    logic        timeout_clr, timeout_err;

    int n_checks = 0;
    int n_err    = 0;
    bit err_exp  = 1'b0;
    bit last_d   = 1'b0;

    lc3b_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_addr      (i_addr),
        .i_resp      (i_resp),
        .i_rdata     (i_rdata),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_wmask     (d_wmask),
        .d_resp      (d_resp),
        .d_rdata     (d_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .timeout_clr (timeout_clr),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".mem_read"}, mem_read, 1'b0);
        check({tag, ".mem_write"}, mem_write, 1'b0);
        check({tag, ".i_resp"}, i_resp, 1'b0);
        check({tag, ".d_resp"}, d_resp, 1'b0);
        check({tag, ".timeout_err"}, timeout_err, err_exp);
    endtask

    // One round: raise the chosen requests, then serve each in the predicted order.
    // k1/k2 give the busy cycle in which memory answers; beyond TO it never answers in time.
    task automatic run_round(input bit ri, input bit rd, input bit dw,
                             input logic [15:0] ia, input logic [15:0] da,
                             input logic [15:0] wd, input logic [1:0] wm,
                             input int k1, input int k2, input bit clr_at_to);
        bit pend_i, pend_d, side_d, done;
        int k, nserved;
        logic [15:0] rd_v, exp_addr;
        @(posedge clk); #1;
        i_read = ri; i_addr = ia;
        d_read = rd; d_write = dw; d_addr = da; d_wdata = wd; d_wmask = wm;
        pend_i = ri; pend_d = rd | dw; nserved = 0;
        while (pend_i || pend_d) begin
            if (pend_i && pend_d) side_d = RR_EN ? !last_d : 1'b1;
            else side_d = pend_d;
            last_d = side_d;
            k = (nserved == 0) ? k1 : k2;
            exp_addr = side_d ? da : {ia[15:1], 1'b0};
            @(posedge clk);
            for (int c = 1; c <= TO; c++) begin
                #1;
                mem_resp = (c == k);
                rd_v = 16'($urandom);
                mem_rdata = rd_v;
                timeout_clr = clr_at_to && (c == TO) && (k > TO);
                @(negedge clk);
                done = (c == k) || (c == TO);
                check("mem_read", mem_read, !side_d || !dw);
                check("mem_write", mem_write, side_d && dw);
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wmask", mem_wmask, (side_d && dw) ? wm : 2'b00);
                if (side_d && dw) check("mem_wdata", mem_wdata, wd);
                check("i_resp", i_resp, !side_d && done);
                check("d_resp", d_resp, side_d && done);
                check("i_rdata", i_rdata, (!side_d && c == k) ? rd_v : 16'h0000);
                check("d_rdata", d_rdata, (side_d && c == k) ? rd_v : 16'h0000);
                check("busy.timeout_err", timeout_err, err_exp);
                @(posedge clk);
                if (done) break;
            end
            if (k > TO) err_exp = 1'b1;
            #1;
            mem_resp = 1'b0;
            timeout_clr = ($urandom_range(0, 3) == 0);
            if (side_d) begin
                d_read = 1'b0; d_write = 1'b0; pend_d = 1'b0;
            end else begin
                i_read = 1'b0; pend_i = 1'b0;
            end
            @(negedge clk);
            check_idle_outputs("post");
            if (timeout_clr) err_exp = 1'b0;
            nserved++;
        end
        @(posedge clk); #1;
        timeout_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        mem_resp = 1'b0; mem_rdata = '0; timeout_clr = 1'b0;
        #12;
        check_idle_outputs("reset");
        check("reset.mem_addr", mem_addr, 16'h0000);
        check("reset.mem_wdata", mem_wdata, 16'h0000);
        check("reset.mem_wmask", mem_wmask, 2'b00);
        check("reset.i_rdata", i_rdata, 16'h0000);
        check("reset.d_rdata", d_rdata, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases: fetch, write, collision, watchdog, set/clear race, second collision.
        run_round(1, 0, 0, 16'h3001, 16'h0000, 16'h0000, 2'b00, 3, 1, 0);
        run_round(0, 0, 1, 16'h0000, 16'h4005, 16'hAB00, 2'b10, 2, 1, 0);
        run_round(1, 1, 0, 16'h1235, 16'h2222, 16'h0000, 2'b00, 2, 1, 0);
        run_round(0, 1, 0, 16'h0000, 16'h5000, 16'h0000, 2'b00, 6, 1, 0);
        run_round(0, 1, 0, 16'h0000, 16'h5002, 16'h0000, 2'b00, 6, 1, 1);
        run_round(1, 1, 0, 16'h0101, 16'h0202, 16'h0000, 2'b00, 1, 4, 0);

        // A memory response while idle must be ignored.
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 16'hFFFF;
        @(negedge clk);
        check("stale.i_resp", i_resp, 1'b0);
        check("stale.d_resp", d_resp, 1'b0);
        check("stale.i_rdata", i_rdata, 16'h0000);
        check("stale.d_rdata", d_rdata, 16'h0000);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        check_idle_outputs("stale_after");

        // Force a sticky error, then reset in the middle of a fetch.
        run_round(1, 0, 0, 16'h7777, 16'h0000, 16'h0000, 2'b00, 6, 1, 0);
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = 16'h3001;
        @(posedge clk); #1;
        check("rst_mid.busy_mem_read", mem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        err_exp = 1'b0;
        last_d = 1'b0;
        check_idle_outputs("rst_mid");
        i_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_after");

        for (int n = 0; n < 200; n++) begin
            bit ri, rd, dw;
            int sel;
            sel = $urandom_range(1, 7);
            ri = sel[0]; rd = sel[1]; dw = sel[2];
            run_round(ri, rd, dw, 16'($urandom), 16'($urandom), 16'($urandom),
                      2'($urandom_range(0, 3)), $urandom_range(1, 6), $urandom_range(1, 6),
                      ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
